// File: rtl/apb_master_if.sv
// Local command/response port and APB requester/completer signals for apb_master.
// The master modport is the APB requester side; slave is the user/completer side.
interface apb_master_if;
  // Local command side
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  // APB bus
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // Local response side
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR,
    output cmd_ready,
    output PSELx,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output rsp_timeout,
    output busy
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    output PRDATA,
    output PREADY,
    output PSLVERR,
    input  cmd_ready,
    input  PSELx,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  rsp_timeout,
    input  busy
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one outstanding transfer through an IDLE/SETUP/ACCESS FSM, all outputs registered.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that see no PREADY for TIMEOUT_CYCLES cycles.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  apb_master_if.master bus_if
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("apb_master: TIMEOUT_CYCLES must lie in 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q,      busy_d;
  logic        psel_q,      psel_d;
  logic        penable_q,   penable_d;
  logic        pwrite_q,    pwrite_d;
  logic [31:0] paddr_q,     paddr_d;
  logic [31:0] pwdata_q,    pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        accept;
  logic        complete;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;
`endif

  // cmd_ready_q is low for the first cycle after reset release, so no accept can happen then.
  assign accept = (state_q == S_IDLE) && bus_if.cmd_valid && cmd_ready_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    complete    = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (accept) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus_if.cmd_write;
          paddr_d   = bus_if.cmd_addr;
          pwdata_d  = bus_if.cmd_wdata;
        end
      end

      S_SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        if (bus_if.PREADY) begin
          complete    = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'h0 : bus_if.PRDATA;
          rsp_err_d   = bus_if.PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          // This is the TIMEOUT_CYCLES-th stalled cycle; PREADY in it would have won above.
          complete      = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (complete) begin
      state_d     = S_IDLE;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      pwrite_d    = 1'b0;
      paddr_d     = 32'h0;
      pwdata_d    = 32'h0;
      rsp_valid_d = 1'b1;
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus_if.rsp_timeout = rsp_timeout_q;
`else
  assign bus_if.rsp_timeout = 1'b0;
`endif

  assign bus_if.cmd_ready = cmd_ready_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.PSELx     = psel_q;
  assign bus_if.PENABLE   = penable_q;
  assign bus_if.PWRITE    = pwrite_q;
  assign bus_if.PADDR     = paddr_q;
  assign bus_if.PWDATA    = pwdata_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, random transfers against a
// cycle-count model, plus reset-abort and long-stall sequences.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  apb_master_if bif ();

  apb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus_if (bif)
  );

  always #5 PCLK = ~PCLK;

  // lat: edges from accept to the cycle showing rsp_valid; psel/pen: cycles each is high.
  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          to;
    int          lat;
    int          psel;
    int          pen;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    bit          err;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: a transfer with `waits` stalled ACCESS cycles, optionally cut off by the timeout.
  function automatic exp_t model(input bit wr, input int waits, input logic [31:0] prdata,
                                 input bit err);
    exp_t e;
    if (TO_EN && waits >= TO) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.to    = 1'b1;
      e.pen   = TO;
    end else begin
      e.rdata = wr ? 32'h0 : prdata;
      e.err   = err;
      e.to    = 1'b0;
      e.pen   = waits + 1;
    end
    e.psel = e.pen + 1;
    e.lat  = e.pen + 2;
    return e;
  endfunction

  task automatic noise();
    bif.PREADY  = 1'($urandom);
    bif.PSLVERR = 1'($urandom);
    bif.PRDATA  = $urandom;
  endtask

  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] prdata, input int waits, input bit err,
                          input exp_t e, input string nm);
    int          cyc    = 0;
    int          acc    = 0;
    int          psel_n = 0;
    int          pen_n  = 0;
    int          bad    = 0;
    int          rv_at  = -1;
    logic [31:0] r_rdata = 32'h0;
    logic        r_err   = 1'b0;
    logic        r_to    = 1'b0;
    @(negedge PCLK);
    chk({nm, ".cmd_ready"}, {31'h0, bif.cmd_ready}, 32'h1);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wdata;
    noise();
    while (rv_at < 0 && cyc < e.lat + 20) begin
      @(negedge PCLK);
      cyc++;
      if (bif.PSELx) begin
        psel_n++;
        if (bif.PADDR !== addr || bif.PWRITE !== wr || bif.PWDATA !== wdata ||
            bif.busy !== 1'b1 || bif.cmd_ready !== 1'b0) bad++;
      end
      if (bif.PENABLE) pen_n++;
      if (bif.rsp_valid) begin
        rv_at   = cyc;
        r_rdata = bif.rsp_rdata;
        r_err   = bif.rsp_err;
        r_to    = bif.rsp_timeout;
      end
      // Command inputs churn while busy and must be ignored.
      bif.cmd_valid = (rv_at < 0) ? 1'($urandom) : 1'b0;
      bif.cmd_write = 1'($urandom);
      bif.cmd_addr  = $urandom;
      bif.cmd_wdata = $urandom;
      if (bif.PSELx && bif.PENABLE) begin
        acc++;
        if (acc > waits) begin
          bif.PREADY  = 1'b1;
          bif.PRDATA  = prdata;
          bif.PSLVERR = err;
        end else begin
          bif.PREADY  = 1'b0;
          bif.PRDATA  = $urandom;
          bif.PSLVERR = 1'($urandom);
        end
      end else begin
        noise();
      end
    end
    chk({nm, ".latency"}, rv_at, e.lat);
    chk({nm, ".psel_cycles"}, psel_n, e.psel);
    chk({nm, ".penable_cycles"}, pen_n, e.pen);
    chk({nm, ".bus_stable"}, bad, 0);
    chk({nm, ".rsp_rdata"}, r_rdata, e.rdata);
    chk({nm, ".rsp_err_to"}, {30'h0, r_err, r_to}, {30'h0, e.err, e.to});
    @(negedge PCLK);
    chk({nm, ".idle_ctrl"},
        {26'h0, bif.rsp_valid, bif.PSELx, bif.PENABLE, bif.PWRITE, bif.busy, bif.cmd_ready},
        32'h1);
    chk({nm, ".idle_bus"}, bif.PADDR | bif.PWDATA, 32'h0);
    chk({nm, ".rsp_held"}, bif.rsp_rdata, e.rdata);
    noise();
  endtask

  vec_t vecs[5];

  initial begin
    int rv_n;
    bit          wr;
    logic [31:0] pr;
    int          w;
    bit          er;

    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 32'h0;
    bif.cmd_wdata = 32'h0;
    bif.PRDATA    = 32'h0;
    bif.PREADY    = 1'b0;
    bif.PSLVERR   = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 0, 1'b0,
                '{32'h0, 1'b0, 1'b0, 3, 2, 1}};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 3, 1'b0,
                '{32'h1234_5678, 1'b0, 1'b0, 6, 5, 4}};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1, 1'b1,
                '{32'hCAFE_F00D, 1'b1, 1'b0, 4, 3, 2}};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0, 32'hAAAA_5555, 2, 1'b1,
                '{32'h0, 1'b1, 1'b0, 5, 4, 3}};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h1111_1111, 32'hFFFF_FFFF, 0, 1'b0,
                '{32'hFFFF_FFFF, 1'b0, 1'b0, 3, 2, 1}};

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("reset.ctrl",
        {24'h0, bif.PSELx, bif.PENABLE, bif.PWRITE, bif.rsp_valid, bif.rsp_err,
         bif.rsp_timeout, bif.busy, bif.cmd_ready}, 32'h0);
    chk("reset.data", bif.PADDR | bif.PWDATA | bif.rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("reset.release_ready", {31'h0, bif.cmd_ready}, 32'h1);

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata, vecs[i].waits,
               vecs[i].err, vecs[i].e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      wr = 1'($urandom);
      pr = $urandom;
      w  = int'($urandom_range(0, 6));
      er = 1'($urandom);
      run_xfer(wr, $urandom, $urandom, pr, w, er, model(wr, w, pr, er),
               $sformatf("rnd%0d", i));
    end

    // Long stall: aborts at the limit with the timeout built in, otherwise still in ACCESS at 100.
    run_xfer(1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 100, 1'b0,
             model(1'b0, 100, 32'h0BAD_F00D, 1'b0), "stall");

    // Reset in the middle of ACCESS abandons the transfer silently.
    rv_n = 0;
    @(negedge PCLK);
    chk("rst_access.cmd_ready", {31'h0, bif.cmd_ready}, 32'h1);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 32'h0000_0040;
    bif.cmd_wdata = 32'h0F0F_0F0F;
    bif.PREADY    = 1'b0;
    @(negedge PCLK);
    bif.cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("rst_access.in_access", {30'h0, bif.PSELx, bif.PENABLE}, 32'h3);
    @(negedge PCLK);
    if (bif.rsp_valid) rv_n++;
    PRESETn     = 1'b0;
    bif.PREADY  = 1'b1;
    bif.PSLVERR = 1'b1;
    @(negedge PCLK);
    chk("rst_access.ctrl",
        {24'h0, bif.PSELx, bif.PENABLE, bif.PWRITE, bif.rsp_valid, bif.rsp_err,
         bif.rsp_timeout, bif.busy, bif.cmd_ready}, 32'h0);
    chk("rst_access.data", bif.PADDR | bif.PWDATA | bif.rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (bif.rsp_valid) rv_n++;
      if (i == 0) chk("rst_access.ready_after", {31'h0, bif.cmd_ready}, 32'h1);
    end
    chk("rst_access.no_rsp", rv_n, 0);
    run_xfer(1'b0, 32'h0000_0044, 32'h0, 32'h7654_3210, 1, 1'b0,
             model(1'b0, 1, 32'h7654_3210, 1'b0), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
